// File: rtl/piso_serializer_tx.sv
// Parallel-in serial-out transmitter: one-entry hold register in front of a shifter,
// with a valid-qualified bit stream, end-of-word pulse and a programmable idle gap.
module piso_serializer_tx #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] par_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             word_done
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full, hold_full_nxt;
    logic [CW-1:0]    bit_cnt, cnt_nxt;
    logic [GW-1:0]    gap_cnt, gap_nxt;
    logic             so_nxt, sv_nxt, wd_nxt;
    logic             reload;
    logic             accept;

    assign accept     = load_valid && !hold_full;
    assign load_ready = !hold_full;
    assign busy       = (state != IDLE) || hold_full;

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        cnt_nxt       = bit_cnt;
        gap_nxt       = gap_cnt;
        hold_full_nxt = hold_full;
        so_nxt        = 1'b0;
        sv_nxt        = 1'b0;
        wd_nxt        = 1'b0;
        reload        = 1'b0;
        case (state)
            IDLE: reload = hold_full;
            SHIFT: begin
                if (bit_cnt != '0) begin
                    shreg_nxt = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                    cnt_nxt   = bit_cnt - CW'(1);
                    so_nxt    = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
                    sv_nxt    = 1'b1;
                    wd_nxt    = (bit_cnt == CW'(1));
                end else if (GAP_CYCLES > 0) begin
                    state_nxt = GAP;
                    gap_nxt   = GAP_LOAD;
                    shreg_nxt = '0;
                end else if (hold_full) begin
                    reload = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    shreg_nxt = '0;
                end
            end
            GAP: begin
                if (gap_cnt != '0)  gap_nxt = gap_cnt - GW'(1);
                else if (hold_full) reload = 1'b1;
                else                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reload presents the first bit straight away so back-to-back words have no bubble.
        if (reload) begin
            state_nxt     = SHIFT;
            shreg_nxt     = hold_reg;
            cnt_nxt       = CNT_LOAD;
            so_nxt        = MSB_FIRST ? hold_reg[WIDTH-1] : hold_reg[0];
            sv_nxt        = 1'b1;
            hold_full_nxt = 1'b0;
        end
        if (accept) hold_full_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            hold_full    <= 1'b0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            word_done    <= 1'b0;
        end else begin
            state        <= state_nxt;
            shreg        <= shreg_nxt;
            bit_cnt      <= cnt_nxt;
            gap_cnt      <= gap_nxt;
            hold_full    <= hold_full_nxt;
            serial_out   <= so_nxt;
            serial_valid <= sv_nxt;
            word_done    <= wd_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         hold_reg <= '0;
        else if (accept) hold_reg <= par_in;
    end
endmodule

// File: tb/tb_piso_serializer_tx.sv
// Bench for piso_serializer_tx: three configurations checked every cycle against a
// word-timeline model, plus literal stream checks for the directed scenarios.
module tb_piso_serializer_tx;
    logic       clk, rst;
    logic [3:0] par [3];
    logic [2:0] lv, lr, so, sv, bz, wd;

    int nchk = 0, npass = 0;

    piso_serializer_tx #(.WIDTH(4), .GAP_CYCLES(1), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .par_in(par[0]), .load_valid(lv[0]), .load_ready(lr[0]),
        .serial_out(so[0]), .serial_valid(sv[0]), .busy(bz[0]), .word_done(wd[0]));
    piso_serializer_tx #(.WIDTH(4), .GAP_CYCLES(0), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst(rst), .par_in(par[1]), .load_valid(lv[1]), .load_ready(lr[1]),
        .serial_out(so[1]), .serial_valid(sv[1]), .busy(bz[1]), .word_done(wd[1]));
    piso_serializer_tx #(.WIDTH(4), .GAP_CYCLES(2), .MSB_FIRST(1'b0)) u2 (
        .clk(clk), .rst(rst), .par_in(par[2]), .load_valid(lv[2]), .load_ready(lr[2]),
        .serial_out(so[2]), .serial_valid(sv[2]), .busy(bz[2]), .word_done(wd[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timeline model: a word accepted at edge N starts at edge max(N+1, prev_start+W+GAP)
    // and its bits appear after edges start..start+W-1.
    int         gapc [3] = '{1, 0, 2};
    bit         msbf [3] = '{1'b1, 1'b1, 1'b0};
    bit         cur_v [3], hold_v [3];
    int         cur_s [3], hold_n [3];
    logic [3:0] cur_w [3], hold_w [3];
    int         cyc;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            cur_v[i] = 0; hold_v[i] = 0; cur_s[i] = 0; hold_n[i] = 0;
            cur_w[i] = '0; hold_w[i] = '0;
        end
    endtask

    task automatic model_step();
        bit acc;
        int s;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            acc = lv[i] && !hold_v[i];
            if (hold_v[i]) begin
                s = hold_n[i] + 1;
                if (cur_v[i] && cur_s[i] + 4 + gapc[i] > s) s = cur_s[i] + 4 + gapc[i];
                if (cyc == s) begin
                    cur_v[i] = 1; cur_s[i] = cyc; cur_w[i] = hold_w[i]; hold_v[i] = 0;
                end
            end
            if (acc) begin
                hold_v[i] = 1; hold_n[i] = cyc; hold_w[i] = par[i];
            end
        end
    endtask

    task automatic exp_out(input int i, output logic [4:0] e);
        int j;
        logic eso, esv, ewd, ebz;
        j   = cyc - cur_s[i];
        esv = cur_v[i] && (j >= 0) && (j < 4);
        eso = 1'b0;
        if (esv) eso = cur_w[i][msbf[i] ? 3 - j : j];
        ewd = esv && (j == 3);
        ebz = hold_v[i] || (cur_v[i] && (j < 4 + gapc[i]));
        e   = {eso, esv, ewd, ebz, !hold_v[i]};
    endtask

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Every-cycle compare of {serial_out, serial_valid, word_done, busy, load_ready}.
    initial forever begin
        logic [4:0] e, a;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            exp_out(i, e);
            a = {so[i], sv[i], wd[i], bz[i], lr[i]};
            nchk++;
            if (a === e) npass++;
            else $display("FAIL cycle inst=%0d cyc=%0d got(so,sv,wd,bz,lr)=%b required=%b", i, cyc, a, e);
        end
    end

    task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] req);
        nchk++;
        if (got === req) npass++;
        else $display("FAIL %s inst=%0d got=%0h required=%0h", name, i, got, req);
    endtask

    logic [11:0] rec_so [3], rec_sv [3];
    int          nwd [3];
    logic [11:0] x_so [3] = '{12'b101100110000, 12'b100101110000, 12'b110100011000};
    logic [11:0] x_sv [3] = '{12'b111101111000, 12'b111111110000, 12'b111100111100};

    initial begin
        rst = 1'b0; lv = '0;
        for (int i = 0; i < 3; i++) par[i] = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk("reset_outs", i, {so[i], sv[i], wd[i], bz[i], lr[i]}, 5'b00001);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed: two words back to back, second offered as soon as ready rises.
        #1;
        par[0] = 4'b1011; par[1] = 4'b1001; par[2] = 4'b1011; lv = 3'b111;
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) chk("ready_low_after_accept", i, lr[i], 1'b0);
        par[0] = 4'b0110; par[1] = 4'b0111; par[2] = 4'b0110;
        for (int i = 0; i < 3; i++) nwd[i] = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                rec_so[i][11-n] = so[i];
                rec_sv[i][11-n] = sv[i];
                nwd[i] += int'(wd[i]);
            end
            if (n == 1) lv = '0;
        end
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("stream_bits", i, rec_so[i], x_so[i]);
            chk("stream_valid", i, rec_sv[i], x_sv[i]);
            chk("word_done_count", i, nwd[i], 2);
            chk("idle_after", i, bz[i], 1'b0);
        end

        // Directed: async reset during the 2nd bit with a word pending.
        repeat (2) @(negedge clk);
        #1; for (int i = 0; i < 3; i++) par[i] = 4'b1111;
        lv = 3'b111;
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) par[i] = 4'b1010;
        repeat (2) @(negedge clk);
        #1; lv = '0;
        for (int i = 0; i < 3; i++) chk("pre_reset_bit", i, {so[i], sv[i], lr[i]}, 3'b110);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++)
            chk("async_reset_outs", i, {so[i], sv[i], wd[i], bz[i], lr[i]}, 5'b00001);
        @(negedge clk); #1 rst = 1'b0;
        repeat (8) @(negedge clk);

        // Random traffic with occasional mid-run async resets.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (!(lv[i] && hold_v[i])) begin
                    lv[i]  = ($urandom_range(0, 3) < ((c / 250) % 3 + 1));
                    par[i] = 4'($urandom);
                end
            end
            if (c % 400 == 399) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        lv = '0;
        repeat (12) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/piso_serializer_tx.md
Name: piso_serializer_tx

Overview:
Parallel-in serial-out transmitter that sits directly upstream of the 4-bit SISO shift register and drives its serial_in. It accepts a WIDTH-bit word over a valid/ready handshake into a one-entry holding register. It then shifts the word out one bit per clock, with a qualifying valid, an end-of-word pulse and a programmable idle gap between words.

Parameters:
WIDTH, 4, word width in bits (>=2)
GAP_CYCLES, 1, idle cycles inserted after each word (0 = back-to-back words)
MSB_FIRST, 1, 1 = shift left with MSB out first; 0 = shift right with LSB out first

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
par_in  input  WIDTH  parallel word to transmit
load_valid  input  1  par_in is valid
load_ready  output  1  hold register empty; a word is accepted at an edge where load_valid && load_ready
serial_out  output  WIDTH-agnostic 1  serial bit stream; connects to the downstream serial_in
serial_valid  output  1  serial_out carries a data bit this cycle
busy  output  1  high in SHIFT or GAP, or while the hold register is full
word_done  output  1  one-cycle pulse during the cycle the last bit of a word is on serial_out

Behaviour:
- Reset (asynchronous, any time, including mid-word):
  - State goes to IDLE. Shift register, bit counter and gap counter clear to 0. Hold register is marked empty and its contents are discarded.
  - Outputs: serial_out=0, serial_valid=0, word_done=0, busy=0, load_ready=1.
- All outputs except load_ready and busy are registered. load_ready = !hold_full, taken from a register with no combinational path from load_valid. busy = (state!=IDLE) || hold_full.
- Handshake:
  - Accept at the edge where load_valid && load_ready. The word is copied to the hold register and hold_full is set.
  - load_valid while load_ready=0 is ignored; upstream must hold par_in stable.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: serial_out=0, serial_valid=0. If hold_full at an edge, move the hold word to the shift register, clear hold_full, load the bit counter with WIDTH-1 and go to SHIFT. From that edge serial_out holds the first bit (MSB if MSB_FIRST) and serial_valid=1.
  - Latency: accept edge N gives first bit valid after edge N+1. WIDTH data cycles follow.
  - SHIFT: at each edge, shift by one and present the next bit; the counter decrements. While counter==0 the last bit is on serial_out and word_done=1.
  - Exit from SHIFT at the edge ending the last bit:
    - GAP_CYCLES>0: go to GAP. serial_out=0, serial_valid=0.
    - GAP_CYCLES=0 and hold_full: reload directly and stay in SHIFT, so the next word's first bit follows with no idle cycle.
    - GAP_CYCLES=0 and hold empty: go to IDLE.
  - GAP: lasts exactly GAP_CYCLES cycles. Then reload if hold_full, else go to IDLE.
- Hold register may be refilled while SHIFT/GAP is in progress. This allows one word in flight plus one word pending.
- Simultaneous events:
  - A hold drain and a new accept never occur at the same edge, because load_ready=0 while hold_full.
  - The first accept after a drain happens no earlier than the next edge.
- MSB_FIRST=0: same timing; bits are emitted LSB first.
- serial_out is held at 0 whenever serial_valid=0, so the downstream register shifts in zeros when idle.

Test Plan:
1. Assert rst for 2 cycles, then release -> serial_out=0, serial_valid=0, load_ready=1, busy=0 and word_done=0, from reset assertion onward.
2. WIDTH=4, GAP=1, accept par_in=4'b1011 -> one cycle later serial_out shows 1,0,1,1 on 4 consecutive cycles with serial_valid=1. word_done is high on the 4th cycle only, followed by exactly 1 idle cycle, then IDLE and busy=0.
3. Accept 4'b1011, then 4'b0110 as soon as load_ready rises -> load_ready=0 from the first accept until the first word moves to shift. Stream is 1,0,1,1, one gap cycle, then 0,1,1,0. Exactly two word_done pulses.
4. GAP_CYCLES=0, two words 4'b1001 and 4'b0111 queued -> 8 contiguous valid bits 1,0,0,1,0,1,1,1 with no idle cycle between words.
5. MSB_FIRST=0, accept 4'b1011 -> serial_out is 1,1,0,1.
6. Assert rst asynchronously (not on a clock edge) during the 2nd bit of 4'b1111 with a second word pending -> outputs return to reset values immediately. The pending word is dropped, and nothing is emitted until a new accept.
